prbs_checker: RTL and testbench

- Receive-side counterpart of the `prbs` generator.
- Samples the recovered bit stream from `cdr` (`data_out` on `clk_out`) and self-synchronises to the PRBS7 sequence (x^7 + x^6 + 1).
- After synchronising, it flags and counts bit errors. This gives the link bench a lock indicator and a BER figure.

---
 rtl/prbs_checker_if.sv | 23 ++
 rtl/prbs_checker.sv | 153 +++++++++++++++
 tb/tb_prbs_checker.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/prbs_checker_if.sv
// Bundle of the checker's data-path signals: the received bit and clear control in,
// lock/error status out.
`timescale 1ns/1ps
interface prbs_checker_if #(
    parameter int ERR_WIDTH = 16
);
    logic                 data_in;
    logic                 clr_err;
    logic                 locked;
    logic                 err_pulse;
    logic [ERR_WIDTH-1:0] err_count;
    logic [1:0]           state;

    modport master (
        output data_in, clr_err,
        input  locked, err_pulse, err_count, state
    );

    modport slave (
        input  data_in, clr_err,
        output locked, err_pulse, err_count, state
    );
endinterface

// File: rtl/prbs_checker.sv
// PRBS7 (x^7 + x^6 + 1) receive checker: self-synchronises to the incoming stream,
// then flags and counts bit errors with window-based loss-of-lock detection.
`timescale 1ns/1ps
module prbs_checker #(
    parameter int LOCK_COUNT = 16,
    parameter int WINDOW     = 64,
    parameter int LOSS_COUNT = 8,
    parameter int ERR_WIDTH  = 16
) (
    input logic           rx_clk,
    input logic           rst,
    prbs_checker_if.slave bus
);
    localparam int WB = $clog2(WINDOW);
    localparam int WE = WB + 1;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        SEARCH = 2'd1,
        LOCKED = 2'd2
    } state_t;

    function automatic logic prbs7_predict(input logic [6:0] h);
        return h[6] ^ h[5];
    endfunction

    state_t               state_q, state_d;
    logic [6:0]           hist_q, hist_d;
    logic [6:0]           shadow_q, shadow_d;
    logic [2:0]           fill_q, fill_d;
    logic [7:0]           match_q, match_d;
    logic [WB-1:0]        win_bit_q, win_bit_d;
    logic [WE-1:0]        win_err_q, win_err_d;
    logic                 locked_q, locked_d;
    logic                 err_pulse_q, err_pulse_d;
    logic [ERR_WIDTH-1:0] err_count_q, err_count_d;
    logic                 p_s;
    logic                 err_s;
    logic [WE-1:0]        win_tot_s;

    // Next-state, history and window bookkeeping for the sync state machine.
    always_comb begin
        state_d   = state_q;
        hist_d    = hist_q;
        shadow_d  = {shadow_q[5:0], bus.data_in};
        fill_d    = fill_q;
        match_d   = match_q;
        win_bit_d = win_bit_q;
        win_err_d = win_err_q;
        err_s     = 1'b0;
        p_s       = prbs7_predict(hist_q);
        win_tot_s = win_err_q;
        case (state_q)
            FILL: begin
                hist_d = {hist_q[5:0], bus.data_in};
                if (fill_q == 3'd6) begin
                    fill_d  = 3'd0;
                    state_d = SEARCH;
                end else begin
                    fill_d = fill_q + 3'd1;
                end
            end
            SEARCH: begin
                hist_d = {hist_q[5:0], bus.data_in};
                // An all-zero history predicts zero forever, so it must never count towards lock.
                if (hist_q == 7'd0) begin
                    match_d = 8'd0;
                end else if (bus.data_in == p_s) begin
                    if (match_q == 8'(LOCK_COUNT - 1)) begin
                        state_d   = LOCKED;
                        match_d   = 8'd0;
                        win_bit_d = '0;
                        win_err_d = '0;
                    end else begin
                        match_d = match_q + 8'd1;
                    end
                end else begin
                    match_d = 8'd0;
                end
            end
            LOCKED: begin
                hist_d    = {hist_q[5:0], p_s};
                err_s     = bus.data_in ^ p_s;
                win_bit_d = win_bit_q + WB'(1);
                win_tot_s = win_err_q + WE'(err_s);
                if (win_bit_q == WB'(WINDOW - 1)) begin
                    win_err_d = '0;
                    // Resynchronise from the raw received bits rather than the free-running history.
                    if (win_tot_s >= WE'(LOSS_COUNT)) begin
                        state_d = SEARCH;
                        hist_d  = shadow_d;
                        match_d = 8'd0;
                    end else begin
                        state_d = LOCKED;
                    end
                end else begin
                    win_err_d = win_tot_s;
                end
            end
            default: begin
                state_d = FILL;
                hist_d  = 7'd0;
                fill_d  = 3'd0;
                match_d = 8'd0;
            end
        endcase
    end

    // Registered status outputs; clear wins over a simultaneous error.
    always_comb begin
        locked_d    = (state_d == LOCKED);
        err_pulse_d = err_s;
        if (bus.clr_err) begin
            err_count_d = '0;
        end else if (err_s && (err_count_q != {ERR_WIDTH{1'b1}})) begin
            err_count_d = err_count_q + ERR_WIDTH'(1);
        end else begin
            err_count_d = err_count_q;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge rx_clk or posedge rst) begin
        if (rst) begin
            state_q     <= FILL;
            hist_q      <= 7'd0;
            shadow_q    <= 7'd0;
            fill_q      <= 3'd0;
            match_q     <= 8'd0;
            win_bit_q   <= '0;
            win_err_q   <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            hist_q      <= hist_d;
            shadow_q    <= shadow_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            win_bit_q   <= win_bit_d;
            win_err_q   <= win_err_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
        end
    end

    assign bus.locked    = locked_q;
    assign bus.err_pulse = err_pulse_q;
    assign bus.err_count = err_count_q;
    assign bus.state     = state_q;
endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: a PRBS7 source feeds the checker and per-cycle
// expected outputs go through a scoreboard queue.
`timescale 1ns/1ps
module tb_prbs_checker;
    localparam int EW = 4;

    typedef struct packed {
        logic          lk;
        logic          pl;
        logic [EW-1:0] cnt;
        logic [1:0]    st;
    } obs_t;

    logic rx_clk = 1'b0;
    logic rst    = 1'b1;

    prbs_checker_if #(.ERR_WIDTH(EW)) bus();

    prbs_checker #(
        .LOCK_COUNT(16),
        .WINDOW    (64),
        .LOSS_COUNT(8),
        .ERR_WIDTH (EW)
    ) dut (
        .rx_clk(rx_clk),
        .rst   (rst),
        .bus   (bus)
    );

    always #10 rx_clk = ~rx_clk;

    obs_t          sb_q[$];
    int            n_total = 0;
    int            n_pass  = 0;
    logic [6:0]    gen     = 7'h7f;
    int            wpos    = 0;
    logic          was_locked = 1'b0;
    logic [EW-1:0] exp_cnt = '0;
    string         phase   = "reset";

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One bit: fen forces the line to fval, otherwise PRBS xor inj. Expected outputs queued before the edge.
    task automatic tick(input logic fen, input logic fval, input logic inj, input logic clr,
                        input logic e_lk, input logic [1:0] e_st);
        logic b;
        logic e_pl;
        obs_t got;
        obs_t want;
        b   = gen[6] ^ gen[5];
        gen = {gen[5:0], b};
        if (fen) b = fval;
        else     b = b ^ inj;
        e_pl = inj & was_locked;
        if (clr) exp_cnt = '0;
        else if (e_pl && exp_cnt != {EW{1'b1}}) exp_cnt = exp_cnt + 1'b1;
        was_locked = e_lk;
        sb_q.push_back(obs_t'{e_lk, e_pl, exp_cnt, e_st});
        bus.data_in = b;
        bus.clr_err = clr;
        @(posedge rx_clk);
        #1;
        got = obs_t'{bus.locked, bus.err_pulse, bus.err_count, bus.state};
        if (sb_q.size() == 0) begin
            n_total++;
            $error("FAIL %s: scoreboard empty, observed %0h", phase, got);
        end else begin
            want = sb_q.pop_front();
            chk(phase, 32'(got), 32'(want));
        end
        bus.clr_err = 1'b0;
    endtask

    task automatic lbit(input logic inj, input logic clr, input logic loss);
        tick(1'b0, 1'b0, inj, clr, !loss, loss ? 2'd1 : 2'd2);
        wpos = (wpos + 1) % 64;
    endtask

    task automatic acquire();
        for (int k = 1; k <= 23; k++)
            tick(1'b0, 1'b0, 1'b0, 1'b0, (k >= 23), (k < 7) ? 2'd0 : ((k < 23) ? 2'd1 : 2'd2));
        wpos = 0;
    endtask

    task automatic do_reset();
        @(negedge rx_clk);
        rst = 1'b1;
        #2;
        chk("rst_locked", 32'(bus.locked), 32'd0);
        chk("rst_pulse", 32'(bus.err_pulse), 32'd0);
        chk("rst_count", 32'(bus.err_count), 32'd0);
        chk("rst_state", 32'(bus.state), 32'd0);
        exp_cnt    = '0;
        was_locked = 1'b0;
        @(posedge rx_clk);
        #5;
        rst = 1'b0;
    endtask

    initial begin
        bus.data_in = 1'b0;
        bus.clr_err = 1'b0;
        do_reset();

        phase = "clean_acq";
        acquire();
        for (int i = 0; i < 977; i++) lbit(1'b0, 1'b0, 1'b0);

        phase = "single_err";
        lbit(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 200; i++) lbit(1'b0, 1'b0, 1'b0);
        lbit(1'b0, 1'b1, 1'b0);

        phase = "burst_loss";
        while (wpos != 10) lbit(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) lbit(1'b1, 1'b0, 1'b0);
        while (wpos != 63) lbit(1'b0, 1'b0, 1'b0);
        lbit(1'b0, 1'b0, 1'b1);
        phase = "relock";
        for (int i = 0; i < 15; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2);
        wpos = 0;
        for (int i = 0; i < 20; i++) lbit(1'b0, 1'b0, 1'b0);
        chk("burst_count", 32'(bus.err_count), 32'd8);

        phase = "stuck_line";
        do_reset();
        for (int k = 1; k <= 500; k++) tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, (k < 7) ? 2'd0 : 2'd1);
        for (int k = 0; k < 500; k++)  tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);

        phase = "saturate";
        do_reset();
        acquire();
        for (int w = 0; w < 20; w++) begin
            while (wpos != 5) lbit(1'b0, 1'b0, 1'b0);
            lbit(1'b1, 1'b0, 1'b0);
        end
        chk("sat_count", 32'(bus.err_count), 32'd15);
        while (wpos != 5) lbit(1'b0, 1'b0, 1'b0);
        phase = "clr_vs_err";
        lbit(1'b1, 1'b1, 1'b0);

        phase = "async_rst";
        for (int i = 0; i < 3; i++) lbit(1'b1, 1'b0, 1'b0);
        lbit(1'b0, 1'b0, 1'b0);
        chk("pre_rst_count", 32'(bus.err_count), 32'd3);
        do_reset();
        phase = "post_rst_acq";
        acquire();
        for (int i = 0; i < 7; i++) lbit(1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
